// File: rtl/sobel_binarize.sv
// Binarizes a frame of Sobel magnitudes against a threshold latched at start.
// Optional SOBEL_BINARIZE_EDGE_COUNT_EN adds edge_cnt, the number of 8'hFF pixels written.
module sobel_binarize #(
    parameter logic [1:0] SRC_SEL = 2'b11,
    parameter logic [1:0] DST_SEL = 2'b10,
    parameter int         NPIX    = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    input  logic [7:0]  thr,
    output logic        busy,
    output logic        crd,
    output logic [15:0] caddr_rd,
    input  logic [7:0]  cdata_rd,
    output logic        cwr,
    output logic [15:0] caddr_wr,
    output logic [7:0]  cdata_wr,
`ifdef SOBEL_BINARIZE_EDGE_COUNT_EN
    output logic [16:0] edge_cnt,
`endif
    output logic [1:0]  csel
);

    localparam logic [15:0] LAST_ADDR = 16'(NPIX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] addr_reg, addr_next;
    logic [7:0]  mag_reg, mag_next;
    logic [7:0]  thr_reg, thr_next;
    logic        pix_on;
    logic        start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            addr_reg  <= 16'd0;
            mag_reg   <= 8'd0;
            thr_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            mag_reg   <= mag_next;
            thr_reg   <= thr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        mag_next   = mag_reg;
        thr_next   = thr_reg;
        start      = 1'b0;
        busy       = 1'b0;
        crd        = 1'b0;
        cwr        = 1'b0;
        csel       = 2'b00;
        caddr_rd   = 16'd0;
        caddr_wr   = 16'd0;
        case (state_reg)
            IDLE: begin
                if (ready) begin
                    start      = 1'b1;
                    thr_next   = thr;
                    addr_next  = 16'd0;
                    state_next = RD;
                end
            end
            RD: begin
                busy       = 1'b1;
                crd        = 1'b1;
                csel       = SRC_SEL;
                caddr_rd   = addr_reg;
                mag_next   = cdata_rd;
                state_next = WR;
            end
            WR: begin
                busy     = 1'b1;
                cwr      = 1'b1;
                csel     = DST_SEL;
                caddr_wr = addr_reg;
                // Last pixel leaves addr at NPIX-1 so it never wraps inside a frame
                if (addr_reg == LAST_ADDR) begin
                    state_next = DONE;
                end else begin
                    addr_next  = addr_reg + 16'd1;
                    state_next = RD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pix_on = cwr && (mag_reg >= thr_reg);

    // Output byte is all-ones or all-zeros, so each bit is the same decision
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_wr_bit
            assign cdata_wr[gi] = pix_on;
        end
    endgenerate

`ifdef SOBEL_BINARIZE_EDGE_COUNT_EN
    logic [16:0] edge_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || start) begin
            edge_cnt_reg <= 17'd0;
        end else if (pix_on) begin
            edge_cnt_reg <= edge_cnt_reg + 17'd1;
        end
    end

    assign edge_cnt = edge_cnt_reg;
`endif

endmodule

// File: tb/tb_sobel_binarize.sv
// Directed bench for sobel_binarize with a small frame, bank memory model and per-cycle bus monitor.
`timescale 1ns/1ps
module tb_sobel_binarize;

    localparam int         NPIX    = 64;
    localparam logic [1:0] SRC_SEL = 2'b11;
    localparam logic [1:0] DST_SEL = 2'b10;

    logic        clk = 1'b0;
    logic        reset, ready;
    logic [7:0]  thr;
    logic        busy, crd, cwr;
    logic [15:0] caddr_rd, caddr_wr;
    logic [7:0]  cdata_rd, cdata_wr;
    logic [1:0]  csel;
`ifdef SOBEL_BINARIZE_EDGE_COUNT_EN
    logic [16:0] edge_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] src_mem [0:NPIX-1];
    logic [7:0] dst_mem [0:NPIX-1];
    logic       clr_dst;
    int         mon_addr;

    always #5 clk = ~clk;

    sobel_binarize #(.SRC_SEL(SRC_SEL), .DST_SEL(DST_SEL), .NPIX(NPIX)) dut (
        .clk(clk), .reset(reset), .ready(ready), .thr(thr), .busy(busy),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
`ifdef SOBEL_BINARIZE_EDGE_COUNT_EN
        .edge_cnt(edge_cnt),
`endif
        .csel(csel)
    );

    assign cdata_rd = (crd && csel == SRC_SEL) ? src_mem[caddr_rd[5:0]] : 8'h00;

    always @(posedge clk) begin
        if (clr_dst) begin
            for (int i = 0; i < NPIX; i++) dst_mem[i] <= 8'h55;
        end else if (cwr && csel == DST_SEL) begin
            dst_mem[caddr_wr[5:0]] <= cdata_wr;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bus protocol and address sequencing, every cycle
    always @(negedge clk) begin
        if (!busy) begin
            mon_addr = 0;
            chk("idle_bus", {crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}, 0);
        end else begin
            chk("one_strobe", {30'd0, crd, cwr}, crd ? 2 : 1);
            if (crd) begin
                chk("rd_sel", csel, SRC_SEL);
                chk("rd_addr", caddr_rd, mon_addr);
            end
            if (cwr) begin
                chk("wr_sel", csel, DST_SEL);
                chk("wr_addr", caddr_wr, mon_addr);
                mon_addr++;
            end
        end
    end

    typedef struct {
        logic       ramp;
        logic [7:0] fill;
        logic [7:0] thr;
        int         exp_ones;
        logic       inj;
    } vec_t;

    vec_t vecs [0:6];

    task automatic load_src(input logic ramp, input logic [7:0] fill);
        for (int i = 0; i < NPIX; i++) src_mem[i] = ramp ? 8'(i) : fill;
        @(posedge clk); #1 clr_dst = 1'b1;
        @(posedge clk); #1 clr_dst = 1'b0;
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        int cnt, bad, ones, highs;
        logic [7:0] exp_b;
        logic timeout;
        load_src(v.ramp, v.fill);
        thr = v.thr;
        ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        cnt = 0;
        timeout = 1'b1;
        for (int n = 0; n < 4 * NPIX; n++) begin
            @(negedge clk);
            ready = 1'b0;
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
            cnt++;
            if (v.inj && crd && caddr_rd == 16'd20) begin
                thr = 8'h00;
                ready = 1'b1;
            end
        end
        ready = 1'b0;
        chk("frame_timeout", int'(timeout), 0);
        chk("busy_cycles", cnt, 2 * NPIX);
        highs = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (busy) highs++;
        end
        chk("busy_stays_low", highs, 0);
        bad = 0;
        ones = 0;
        for (int i = 0; i < NPIX; i++) begin
            exp_b = (src_mem[i] >= v.thr) ? 8'hFF : 8'h00;
            if (dst_mem[i] != exp_b) bad++;
            if (dst_mem[i] == 8'hFF) ones++;
        end
        chk("dst_map_bad", bad, 0);
        chk("dst_ones", ones, v.exp_ones);
`ifdef SOBEL_BINARIZE_EDGE_COUNT_EN
        chk("edge_cnt", int'(edge_cnt), v.exp_ones);
`endif
        $display("frame %0d: ramp=%0d fill=%02h thr=%02h inj=%0d cycles=%0d ones=%0d bad=%0d",
                 idx, v.ramp, v.fill, v.thr, v.inj, cnt, ones, bad);
    endtask

    initial begin
        int bad_lo, bad_hi;
        vecs[0] = '{ramp: 1'b0, fill: 8'h80, thr: 8'h80, exp_ones: 64, inj: 1'b0};
        vecs[1] = '{ramp: 1'b1, fill: 8'h00, thr: 8'h10, exp_ones: 48, inj: 1'b0};
        vecs[2] = '{ramp: 1'b0, fill: 8'h00, thr: 8'h00, exp_ones: 64, inj: 1'b0};
        vecs[3] = '{ramp: 1'b0, fill: 8'hFE, thr: 8'hFF, exp_ones: 0,  inj: 1'b0};
        vecs[4] = '{ramp: 1'b0, fill: 8'hFF, thr: 8'hFF, exp_ones: 64, inj: 1'b0};
        vecs[5] = '{ramp: 1'b1, fill: 8'h00, thr: 8'h3F, exp_ones: 1,  inj: 1'b0};
        vecs[6] = '{ramp: 1'b1, fill: 8'h00, thr: 8'h10, exp_ones: 48, inj: 1'b1};

        reset = 1'b1;
        ready = 1'b0;
        thr = 8'h00;
        clr_dst = 1'b0;
        for (int i = 0; i < NPIX; i++) src_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 ready = 1'b1;
        @(negedge clk);
        chk("reset_over_ready_busy", int'(busy), 0);
        chk("reset_outputs", {crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}, 0);
`ifdef SOBEL_BINARIZE_EDGE_COUNT_EN
        chk("reset_edge_cnt", int'(edge_cnt), 0);
`endif
        ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        for (int k = 0; k < 7; k++) run_frame(k, vecs[k]);

        // Abort mid-frame: reset lands on the read of pixel 30
        load_src(1'b0, 8'h80);
        thr = 8'h80;
        ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        for (int n = 0; n < 4 * NPIX; n++) begin
            @(negedge clk);
            if (crd && caddr_rd == 16'd30) break;
        end
        chk("abort_reached_px30", int'(crd && caddr_rd == 16'd30), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_cwr", int'(cwr), 0);
`ifdef SOBEL_BINARIZE_EDGE_COUNT_EN
        chk("abort_edge_cnt", int'(edge_cnt), 0);
`endif
        reset = 1'b0;
        repeat (3) @(negedge clk);
        bad_lo = 0;
        bad_hi = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (i < 30 && dst_mem[i] != 8'hFF) bad_lo++;
            if (i >= 30 && dst_mem[i] != 8'h55) bad_hi++;
        end
        chk("abort_written_below", bad_lo, 0);
        chk("abort_untouched_above", bad_hi, 0);
        $display("abort at pixel 30: bad_below=%0d bad_above=%0d", bad_lo, bad_hi);

        run_frame(7, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
